regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single regfile write port between the in-order pipeline WB stage and the
//  multi-cycle MUL/DIV unit (MDU). Keeps a per-register busy scoreboard for MDU targets,
//  drives decode RAW stalls, buffers one MDU result and enforces MDU anti-starvation.
//  Sits between WB/MDU and regfile write port (rd, write_data, wr_en).
// PARAMETERS
//  XLEN            32  data width
//  REG_ADDR_WIDTH   5  register index width
//  NUM_REGS        32  architectural registers (x0 hardwired zero)
//  STARVE_LIMIT     4  cycles a buffered MDU result may be blocked before forcing its write
// PORTS
//  clk              in   1               clock
//  reset            in   1               async, active-high
//  wb_valid         in   1               pipeline WB has a write this cycle
//  wb_rd            in   REG_ADDR_WIDTH  pipeline destination
//  wb_data          in   XLEN            pipeline result
//  wb_hold          out  1               WB write not taken; WB stage must freeze and re-present
//  mdu_issue_valid  in   1               decode issuing an MDU op
//  mdu_issue_rd     in   REG_ADDR_WIDTH  MDU op destination
//  mdu_issue_ready  out  1               issue accepted (no WAW on rd)
//  mdu_res_valid    in   1               MDU result available
//  mdu_res_rd       in   REG_ADDR_WIDTH  MDU result destination
//  mdu_res_data     in   XLEN            MDU result
//  mdu_res_ready    out  1               result buffer can accept
//  rs1_addr,rs2_addr in  REG_ADDR_WIDTH  decode source operands
//  rs1_stall,rs2_stall out 1             source pending in MDU; decode must stall
//  rf_wr_en         out  1               to regfile wr_en
//  rf_rd            out  REG_ADDR_WIDTH  to regfile rd
//  rf_wr_data       out  XLEN            to regfile write_data
// BEHAVIOUR
//  Interface: one clock (clk); reset asynchronous, active-high.
//  Reset: state=IDLE, busy[*]=0, buf_valid=0, starve_cnt=0. While reset high all outputs 0
//   (rf_wr_en, wb_hold, mdu_issue_ready, mdu_res_ready, rs*_stall).
//  State machine (buffer control):
//   IDLE : buf empty; mdu_res_ready=1. res handshake -> latch rd/data, cnt=0, -> PEND.
//   PEND : mdu_res_ready=0. If !wb_valid: drain buf this cycle -> IDLE.
//          If wb_valid: WB writes, cnt++; when cnt==STARVE_LIMIT-1 -> FORCE.
//   FORCE: wb_hold=1, buf drains regardless of wb_valid, -> IDLE, cnt=0.
//  Write port mux (combinational, same cycle): drain ? buf : (wb_valid && !wb_hold ? WB : none).
//   rf_wr_en=1 for any selected write incl. rd=0 (regfile drops x0). wb_hold=1 only in FORCE.
//  Min MDU result latency: accepted edge N, written to regfile in cycle N+1.
//  Scoreboard: issue handshake with rd!=0 sets busy[rd] at edge; drain clears busy[buf_rd] at edge.
//   Set and clear of different regs same cycle both apply. rd=0 never sets busy.
//  mdu_issue_ready = !busy[mdu_issue_rd] || mdu_issue_rd==0 (same-cycle drain to that rd does
//   NOT make it ready; conservative).
//  rsN_stall = busy[rsN_addr] && !(drain && buf_rd==rsN_addr); rsN_addr==0 -> 0 (regfile
//   bypasses the write in its drain cycle).
//  Pipeline WB to a busy rd is illegal (decode stall prevents it); bench asserts it never occurs.
//  Reset mid-operation: buffered result and busy bits discarded; no write emitted.
// TESTING
//  1 Reset, wb_valid=1 rd=5 data=0xAA -> rf_wr_en=1 rf_rd=5 rf_wr_data=0xAA same cycle, wb_hold=0.
//  2 Issue rd=7; rs1_addr=7 -> rs1_stall=1; res rd=7 data=0x1234, no WB -> written next cycle,
//    rs1_stall=0 in drain cycle, busy[7]=0 after.
//  3 Buffer full, wb_valid held 1 -> WB writes 3 cycles, 4th cycle FORCE: wb_hold=1, rf_rd=buf rd,
//    WB write suppressed, WB re-presented next cycle and written.
//  4 busy[9]=1, issue rd=9 -> mdu_issue_ready=0; issue rd=0 -> ready=1, busy unchanged.
//  5 Drain rd=3 and issue rd=4 same cycle -> busy[3]=0, busy[4]=1 next cycle.
//  6 Assert reset while PEND with busy[12]=1 -> all outputs 0 immediately, no write, busy cleared.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the WB, MDU issue/result, decode operand and regfile write signals of the
// write-port arbiter. The slave modport is the arbiter; the master modport is its environment.
interface regfile_wb_arbiter_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      wb_valid;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [XLEN-1:0]           wb_data;
    logic                      wb_hold;

    logic                      mdu_issue_valid;
    logic [REG_ADDR_WIDTH-1:0] mdu_issue_rd;
    logic                      mdu_issue_ready;

    logic                      mdu_res_valid;
    logic [REG_ADDR_WIDTH-1:0] mdu_res_rd;
    logic [XLEN-1:0]           mdu_res_data;
    logic                      mdu_res_ready;

    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic                      rs1_stall;
    logic                      rs2_stall;

    logic                      rf_wr_en;
    logic [REG_ADDR_WIDTH-1:0] rf_rd;
    logic [XLEN-1:0]           rf_wr_data;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output mdu_issue_valid, mdu_issue_rd,
        output mdu_res_valid, mdu_res_rd, mdu_res_data,
        output rs1_addr, rs2_addr,
        input  wb_hold, mdu_issue_ready, mdu_res_ready,
        input  rs1_stall, rs2_stall,
        input  rf_wr_en, rf_rd, rf_wr_data
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  mdu_issue_valid, mdu_issue_rd,
        input  mdu_res_valid, mdu_res_rd, mdu_res_data,
        input  rs1_addr, rs2_addr,
        output wb_hold, mdu_issue_ready, mdu_res_ready,
        output rs1_stall, rs2_stall,
        output rf_wr_en, rf_rd, rf_wr_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between pipeline WB and the MDU: one-entry MDU result
// buffer with anti-starvation, plus a busy scoreboard that drives decode RAW stalls.
module regfile_wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT) + 1;

    typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

    state_t                    state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] buf_rd_q, buf_rd_d;
    logic [XLEN-1:0]           buf_data_q, buf_data_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [NUM_REGS-1:0]       busy_q, busy_d;
    logic [NUM_REGS-1:0]       busy_set, busy_clr;

    logic drain;
    logic wb_take;
    logic issue_ok;
    logic issue_fire;

    // The buffer leaves through the write port whenever WB is idle, or unconditionally once starved.
    assign drain      = (state_q == PEND && !bus.wb_valid) || (state_q == FORCE);
    assign wb_take    = bus.wb_valid && (state_q != FORCE);
    assign issue_ok   = !busy_q[bus.mdu_issue_rd] || (bus.mdu_issue_rd == '0);
    assign issue_fire = bus.mdu_issue_valid && issue_ok && !reset;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            if (gi == 0) begin : g_x0
                assign busy_set[gi] = 1'b0;
            end else begin : g_xn
                assign busy_set[gi] = issue_fire && (bus.mdu_issue_rd == REG_ADDR_WIDTH'(gi));
            end
            assign busy_clr[gi] = drain && (buf_rd_q == REG_ADDR_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        cnt_d      = cnt_q;
        busy_d     = (busy_q & ~busy_clr) | busy_set;
        case (state_q)
            IDLE: begin
                if (bus.mdu_res_valid) begin
                    buf_rd_d   = bus.mdu_res_rd;
                    buf_data_d = bus.mdu_res_data;
                    cnt_d      = '0;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (!bus.wb_valid) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(STARVE_LIMIT - 2)) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            cnt_q      <= '0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
        end
    end

    // Outputs are forced low for the whole time reset is asserted, not just after the edge.
    assign bus.wb_hold         = !reset && (state_q == FORCE);
    assign bus.mdu_res_ready   = !reset && (state_q == IDLE);
    assign bus.mdu_issue_ready = !reset && issue_ok;
    assign bus.rf_wr_en        = !reset && (drain || wb_take);
    assign bus.rf_rd           = reset ? '0 : drain ? buf_rd_q   : wb_take ? bus.wb_rd   : '0;
    assign bus.rf_wr_data      = reset ? '0 : drain ? buf_data_q : wb_take ? bus.wb_data : '0;

    assign bus.rs1_stall = !reset && (bus.rs1_addr != '0) && busy_q[bus.rs1_addr]
                           && !(drain && buf_rd_q == bus.rs1_addr);
    assign bus.rs2_stall = !reset && (bus.rs2_addr != '0) && busy_q[bus.rs2_addr]
                           && !(drain && buf_rd_q == bus.rs2_addr);
endmodule
